// File: rtl/mdu_multicycle_if.sv
// Multiply/divide unit bus: launch request, operands, CP0 flush and the
// architectural HI/LO view. The pipeline (master) drives the request side;
// the MDU (slave) drives status and results.
interface mdu_multicycle_if #(
  parameter int WIDTH = 32
);

  logic             start;   // launch a multiply/divide class op
  logic [3:0]       op;      // operation code
  logic [WIDTH-1:0] rs;      // operand A, MTHI/MTLO source
  logic [WIDTH-1:0] rt;      // operand B
  logic             cancel;  // exception flush from CP0
  logic             busy;    // operation in flight
  logic             done;    // one-cycle commit pulse
  logic [WIDTH-1:0] hi;      // architectural HI
  logic [WIDTH-1:0] lo;      // architectural LO
  logic [WIDTH-1:0] md_out;  // MFHI/MFLO read data

  modport master (
    output start, op, rs, rt, cancel,
    input  busy, done, hi, lo, md_out
  );

  modport slave (
    input  start, op, rs, rt, cancel,
    output busy, done, hi, lo, md_out
  );

endinterface

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit for the E stage.
// The full result is computed from rs/rt at the launch edge and parked in a
// pending register; a down-counter models the class latency, after which the
// pending value is committed to HI/LO and done pulses for one cycle. A CP0
// cancel drops the in-flight op without touching HI/LO.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU
// (ops 9-12), which accumulate into {HI,LO}. Without it those codes behave as
// NONE and no accumulator adder exists.
module mdu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  mdu_multicycle_if.slave bus
);

  // Counter only has to hold LAT-1 of the slower class.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT <= 1) ? 1 : $clog2(MAX_LAT);

  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // State
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_pend;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Next-state values
  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [2*WIDTH-1:0] w_pend_next;
  logic [WIDTH-1:0]   w_hi_next;
  logic [WIDTH-1:0]   w_lo_next;
  logic               w_done_next;

  // Inputs
  logic               w_start;
  logic [3:0]         w_op;
  logic [WIDTH-1:0]   w_rs;
  logic [WIDTH-1:0]   w_rt;
  logic               w_cancel;

  assign w_start  = bus.start;
  assign w_op     = bus.op;
  assign w_rs     = bus.rs;
  assign w_rt     = bus.rt;
  assign w_cancel = bus.cancel;

  // ---------------------------------------------------------------- decode
  logic w_is_mul;
  logic w_is_div;
  logic w_mul_signed;
  logic w_launch;
  logic w_mt_write;

`ifdef MDU_MADD_EN
  assign w_is_mul = (w_op == OP_MULT)  || (w_op == OP_MULTU) ||
                    (w_op == OP_MADD)  || (w_op == OP_MADDU) ||
                    (w_op == OP_MSUB)  || (w_op == OP_MSUBU);
  assign w_mul_signed = (w_op == OP_MULT) || (w_op == OP_MADD) ||
                        (w_op == OP_MSUB);
`else
  assign w_is_mul     = (w_op == OP_MULT) || (w_op == OP_MULTU);
  assign w_mul_signed = (w_op == OP_MULT);
`endif

  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);

  // Launches and HI/LO moves are only honoured from IDLE; while RUN the
  // stall logic should prevent them, and any that slip through are dropped.
  assign w_launch   = (r_state == S_IDLE) && w_start && !w_cancel &&
                      (w_is_mul || w_is_div);
  assign w_mt_write = (r_state == S_IDLE) && !w_cancel &&
                      ((w_op == OP_MTHI) || (w_op == OP_MTLO));

  // -------------------------------------------------------------- multiply
  // Operands are extended to 2*WIDTH so a single truncated product is the
  // exact signed or unsigned result.
  logic [2*WIDTH-1:0] w_mul_a;
  logic [2*WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_mul_a = w_mul_signed ? {{WIDTH{w_rs[WIDTH-1]}}, w_rs}
                                : {{WIDTH{1'b0}}, w_rs};
  assign w_mul_b = w_mul_signed ? {{WIDTH{w_rt[WIDTH-1]}}, w_rt}
                                : {{WIDTH{1'b0}}, w_rt};
  assign w_prod  = w_mul_a * w_mul_b;

`ifdef MDU_MADD_EN
  // Accumulation uses HI/LO as they stand at the launch edge; wraps modulo
  // 2^(2*WIDTH).
  logic [2*WIDTH-1:0] w_acc;
  logic               w_is_madd;
  logic               w_is_msub;

  assign w_acc     = {r_hi, r_lo};
  assign w_is_madd = (w_op == OP_MADD) || (w_op == OP_MADDU);
  assign w_is_msub = (w_op == OP_MSUB) || (w_op == OP_MSUBU);
  assign w_mul_res = w_is_madd ? (w_acc + w_prod) :
                     w_is_msub ? (w_acc - w_prod) : w_prod;
`else
  assign w_mul_res = w_prod;
`endif

  // ---------------------------------------------------------------- divide
  // Divide on magnitudes, then restore signs: quotient negative when the
  // operand signs differ, remainder takes the dividend's sign. MIN / -1 falls
  // out naturally: |MIN| / 1 = 2^(WIDTH-1), negated wraps back to MIN, rem 0.
  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_div_res;

  assign w_div_signed = (w_op == OP_DIV);
  assign w_a_neg      = w_div_signed && w_rs[WIDTH-1];
  assign w_b_neg      = w_div_signed && w_rt[WIDTH-1];
  assign w_a_mag      = w_a_neg ? (~w_rs + 1'b1) : w_rs;
  assign w_b_mag      = w_b_neg ? (~w_rt + 1'b1) : w_rt;
  assign w_b_zero     = (w_rt == '0);
  // Substitute a harmless divisor for zero so the divider never sees x/0;
  // its result is discarded in that case anyway.
  assign w_b_safe     = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
  assign w_quo_mag    = w_a_mag / w_b_safe;
  assign w_rem_mag    = w_a_mag % w_b_safe;
  assign w_quo        = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 1'b1) : w_quo_mag;
  assign w_rem        = w_a_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
  // Divide by zero still runs the full latency but commits HI/LO unchanged;
  // HI/LO cannot move while RUN, so latching them here is equivalent.
  assign w_div_res    = w_b_zero ? {r_hi, r_lo} : {w_rem, w_quo};

  // ------------------------------------------------------------------- FSM
  // Next-state, counter, pending result and HI/LO update selection.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pend_next  = r_pend;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_next = S_RUN;
          w_cnt_next   = w_is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
          w_pend_next  = w_is_div ? w_div_res : w_mul_res;
        end else if (w_mt_write) begin
          if (w_op == OP_MTHI) begin
            w_hi_next = w_rs;
          end else begin
            w_lo_next = w_rs;
          end
        end
      end

      S_RUN: begin
        if (w_cancel) begin
          // Flush: abandon the pending result, HI/LO untouched.
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          w_state_next = S_IDLE;
          w_hi_next    = r_pend[2*WIDTH-1:WIDTH];
          w_lo_next    = r_pend[WIDTH-1:0];
          w_done_next  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; asynchronous reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_done  <= w_done_next;
    end
  end

  // --------------------------------------------------------------- outputs
  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = r_done;
  assign bus.hi     = r_hi;
  assign bus.lo     = r_lo;
  assign bus.md_out = (w_op == OP_MFHI) ? r_hi :
                      (w_op == OP_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
// Expected {hi,lo} results are pushed to a scoreboard queue at launch and
// popped by a monitor whenever done pulses. Build with +define+MDU_MADD_EN to
// exercise the accumulate ops.
module tb_mdu_multicycle;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mdu_multicycle_if #(.WIDTH(W)) bus_if ();

  mdu_multicycle #(
    .WIDTH  (W),
    .MUL_LAT(ML),
    .DIV_LAT(DL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int           total = 0;
  int           bad   = 0;
  logic [63:0]  sb_q[$];
  logic [31:0]  m_hi = '0;
  logic [31:0]  m_lo = '0;
  logic [63:0]  mon_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model built from 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] acc;
    longint      sp;
    logic [63:0] up;
    int          sq;
    int          sr;
    acc = {m_hi, m_lo};
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1: return sp;
      4'd2: return up;
      4'd3: begin
        if (b == 32'd0) return acc;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        return {sr, sq};
      end
      4'd4: begin
        if (b == 32'd0) return acc;
        return {a % b, a / b};
      end
      4'd9:  return acc + sp;
      4'd10: return acc + up;
      4'd11: return acc - sp;
      4'd12: return acc - up;
      default: return acc;
    endcase
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus_if.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("commit_hilo", {bus_if.hi, bus_if.lo}, mon_exp);
        m_hi = mon_exp[63:32];
        m_lo = mon_exp[31:0];
        $display("commit hi=0x%08h lo=0x%08h exp=0x%016h", bus_if.hi, bus_if.lo, mon_exp);
      end
    end
  end

  // Launch one op, optionally poke a second start mid-flight, and time busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit intrude);
    int n;
    $display("launch op=%0d rs=0x%08h rt=0x%08h", op, a, b);
    bus_if.op    = op;
    bus_if.rs    = a;
    bus_if.rt    = b;
    bus_if.start = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.op    = OP_NONE;
    bus_if.rs    = '0;
    bus_if.rt    = '0;
    n = 0;
    while (bus_if.busy === 1'b1 && n < 40) begin
      n++;
      if (intrude && n == 2) begin
        bus_if.start = 1'b1;
        bus_if.op    = OP_MULT;
        bus_if.rs    = 32'd5;
        bus_if.rt    = 32'd7;
      end else begin
        bus_if.start = 1'b0;
        bus_if.op    = OP_NONE;
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    bus_if.op    = OP_NONE;
    check("busy_cycles", 64'(n), 64'(lat));
    check("done_pulse", {63'd0, bus_if.done}, 64'd1);
    @(negedge clk);
    check("done_one_cycle", {63'd0, bus_if.done}, 64'd0);
  endtask

  // MTHI/MTLO: immediate write, no busy, no done.
  task automatic move_to(input logic [3:0] op, input logic [31:0] v);
    bus_if.op = op;
    bus_if.rs = v;
    @(negedge clk);
    bus_if.op = OP_NONE;
    bus_if.rs = '0;
    if (op == OP_MTHI) begin
      m_hi = v;
      check("mthi", {32'd0, bus_if.hi}, {32'd0, v});
    end else begin
      m_lo = v;
      check("mtlo", {32'd0, bus_if.lo}, {32'd0, v});
    end
    check("mt_no_busy", {63'd0, bus_if.busy}, 64'd0);
    $display("move op=%0d val=0x%08h hi=0x%08h lo=0x%08h", op, v, bus_if.hi, bus_if.lo);
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    check({tag, "_hi"}, {32'd0, bus_if.hi}, {32'd0, eh});
    check({tag, "_lo"}, {32'd0, bus_if.lo}, {32'd0, el});
  endtask

  // Hard time limit so the bench always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus_if.start  = 1'b0;
    bus_if.op     = OP_NONE;
    bus_if.rs     = '0;
    bus_if.rt     = '0;
    bus_if.cancel = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    check("rst_done", {63'd0, bus_if.done}, 64'd0);
    check_hilo("rst", 32'd0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -2 * 3
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, ML, 1'b0);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // Combinational MFHI/MFLO read
    bus_if.op = OP_MFHI;
    #1 check("mfhi", {32'd0, bus_if.md_out}, 64'h0000_0000_FFFF_FFFF);
    bus_if.op = OP_MFLO;
    #1 check("mflo", {32'd0, bus_if.md_out}, 64'h0000_0000_FFFF_FFFA);
    bus_if.op = OP_NONE;
    #1 check("md_none", {32'd0, bus_if.md_out}, 64'd0);
    @(negedge clk);

    // DIV / DIVU of -7 by 2
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, DL, 1'b0);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, DL, 1'b0);
    check_hilo("divu", 32'd1, 32'h7FFF_FFFC);

    // Divide by zero leaves HI/LO, overflow case MIN / -1
    move_to(OP_MTHI, 32'h1234);
    move_to(OP_MTLO, 32'h5678);
    run_op(OP_DIV, 32'd99, 32'd0, DL, 1'b0);
    check_hilo("div0", 32'h1234, 32'h5678);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DL, 1'b0);
    check_hilo("divovf", 32'd0, 32'h8000_0000);

    // Cancel in busy cycle 3 of MULTU
    $display("launch op=%0d rs=0x00010000 rt=0x00010000 (to be cancelled)", OP_MULTU);
    bus_if.op    = OP_MULTU;
    bus_if.rs    = 32'h0001_0000;
    bus_if.rt    = 32'h0001_0000;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.op    = OP_NONE;
    @(negedge clk);
    @(negedge clk);
    check("cancel_pre_busy", {63'd0, bus_if.busy}, 64'd1);
    bus_if.cancel = 1'b1;
    @(negedge clk);
    bus_if.cancel = 1'b0;
    check("cancel_busy", {63'd0, bus_if.busy}, 64'd0);
    check("cancel_done", {63'd0, bus_if.done}, 64'd0);
    repeat (8) @(negedge clk);
    check_hilo("cancel", 32'd0, 32'h8000_0000);

    // Cancel together with MTLO, and together with start
    bus_if.op     = OP_MTLO;
    bus_if.rs     = 32'd5;
    bus_if.cancel = 1'b1;
    @(negedge clk);
    bus_if.op     = OP_DIVU;
    bus_if.rs     = 32'd10;
    bus_if.rt     = 32'd3;
    bus_if.start  = 1'b1;
    check("cancel_mtlo", {32'd0, bus_if.lo}, 64'h0000_0000_8000_0000);
    @(negedge clk);
    bus_if.start  = 1'b0;
    bus_if.cancel = 1'b0;
    bus_if.op     = OP_NONE;
    check("cancel_start", {63'd0, bus_if.busy}, 64'd0);

    // start with a non-launching op
    bus_if.op    = OP_MFHI;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.op    = OP_NONE;
    check("start_mfhi_busy", {63'd0, bus_if.busy}, 64'd0);
    check_hilo("start_mfhi", 32'd0, 32'h8000_0000);

    // start while busy is ignored
    run_op(OP_MULTU, 32'd3, 32'd4, ML, 1'b1);
    check_hilo("intrude", 32'd0, 32'd12);

    // Asynchronous reset in the middle of a DIV
    $display("launch op=%0d rs=0x00000064 rt=0x00000007 (to be reset)", OP_DIV);
    bus_if.op    = OP_DIV;
    bus_if.rs    = 32'd100;
    bus_if.rt    = 32'd7;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.op    = OP_NONE;
    repeat (3) @(negedge clk);
    check("arst_pre_busy", {63'd0, bus_if.busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, bus_if.busy}, 64'd0);
    check_hilo("arst", 32'd0, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DL + 2) @(negedge clk);
    check("arst_no_commit_lo", {32'd0, bus_if.lo}, 64'd0);

    // Accumulate
    move_to(OP_MTHI, 32'd0);
    move_to(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op(OP_MADDU, 32'd1, 32'd1, ML, 1'b0);
    check_hilo("maddu", 32'd1, 32'd0);
`else
    bus_if.op    = OP_MADDU;
    bus_if.rs    = 32'd1;
    bus_if.rt    = 32'd1;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.op    = OP_NONE;
    check("maddu_off_busy", {63'd0, bus_if.busy}, 64'd0);
    @(negedge clk);
    check("maddu_off_busy2", {63'd0, bus_if.busy}, 64'd0);
    check("maddu_off_done", {63'd0, bus_if.done}, 64'd0);
    check_hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

    // Random mix checked against the model
    for (int i = 0; i < 8; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      run_op(rop, ra, rb, (rop >= OP_DIV) ? DL : ML, 1'b0);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
